// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
// Shared definitions for the data-memory arbiter: default bus widths, the
// starvation counter width and the grant encoding used for debug visibility
// and assertions.
package dmem_arb_pkg;

    localparam int AW_DEF   = 32;
    localparam int DW_DEF   = 32;
    localparam int STARVE_W = 4;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CORE = 2'd1,
        GNT_HOST = 2'd2
    } gnt_e;

    function automatic gnt_e gnt_encode(input logic gnt_core, input logic gnt_host);
        if (gnt_host)
            return GNT_HOST;
        else if (gnt_core)
            return GNT_CORE;
        else
            return GNT_NONE;
    endfunction

endpackage

// File: rtl/dmem_arbiter_ctr.sv
// arb_sat_ctr
// Counter with synchronous clear and increment. WRAP=0 saturates at MAX,
// WRAP=1 rolls over at 2^W.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset, counter -> 0
//   clr  - synchronous clear (wins over inc)
//   inc  - increment enable
//   cnt  - current count
module arb_sat_ctr #(
    parameter int              W    = 4,
    parameter logic [W-1:0]    MAX  = '1,
    parameter bit              WRAP = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic at_max;

    generate
        if (WRAP) begin : g_wrap
            assign at_max = 1'b0;
        end else begin : g_sat
            assign at_max = (cnt == MAX);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !at_max)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single-port data memory between the core load/store path and a
// host/DMA port. The core has fixed priority; a pending host request that has
// lost STARVE_LIM consecutive cycles is forced through, stalling the core for
// that cycle. STARVE_LIM must lie in 1..15 (4-bit starvation counter).
// Optional build macro: DMEM_ARB_STATS_EN adds stat_host_gnt / stat_core_stall
// wrapping 32-bit event counters.
// Ports:
//   clk, rst                      - clock, asynchronous active-low reset
//   core_req/we/addr/wdata        - core access request
//   core_rdata, core_stall        - core read data (combinational), stall
//   host_req/we/addr/wdata        - host request, held until host_ack
//   host_ack                      - host access performed this cycle
//   host_rdata, host_rvalid       - registered host read data, one-cycle valid
//   mem_we/addr/wdata, mem_rdata  - data_mem interface (combinational read)
//   stat_host_gnt, stat_core_stall - (DMEM_ARB_STATS_EN only) event counters
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int STARVE_LIM = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic [DW-1:0] core_rdata,
    output logic          core_stall,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ack,
    output logic [DW-1:0] host_rdata,
    output logic          host_rvalid,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]   stat_host_gnt,
    output logic [31:0]   stat_core_stall
`endif
);

    localparam logic [STARVE_W-1:0] LIM = STARVE_W'(STARVE_LIM);

    logic [STARVE_W-1:0] starve_cnt;
    logic                gnt_host;
    logic                gnt_core;
    logic                host_rd_gnt;
    gnt_e                gnt_dbg;

    assign gnt_host    = host_req & (~core_req | (starve_cnt == LIM));
    assign gnt_core    = core_req & ~gnt_host;
    assign host_rd_gnt = gnt_host & ~host_we;
    assign gnt_dbg     = gnt_encode(gnt_core, gnt_host);

    // With no grant the address still follows the core so the combinational
    // read path stays quiet; only the write strobe is withheld.
    always_comb begin
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
        mem_we    = 1'b0;
        if (gnt_host) begin
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
            mem_we    = host_we;
        end else if (gnt_core) begin
            mem_we    = core_we;
        end
        if (!rst)
            mem_we = 1'b0;
    end

    assign core_rdata = mem_rdata;
    assign core_stall = core_req & gnt_host;
    assign host_ack   = gnt_host;

    // Counts consecutive losses of a pending host request; any host grant or
    // an idle host port restarts the count.
    arb_sat_ctr #(
        .W    (STARVE_W),
        .MAX  (LIM),
        .WRAP (1'b0)
    ) u_starve (
        .clk (clk),
        .rst (rst),
        .clr (gnt_host | ~host_req),
        .inc (host_req & gnt_core),
        .cnt (starve_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            host_rdata  <= '0;
            host_rvalid <= 1'b0;
        end else begin
            host_rvalid <= host_rd_gnt;
            if (host_rd_gnt)
                host_rdata <= mem_rdata;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    arb_sat_ctr #(
        .W    (32),
        .MAX  ('1),
        .WRAP (1'b1)
    ) u_stat_host_gnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (gnt_host),
        .cnt (stat_host_gnt)
    );

    arb_sat_ctr #(
        .W    (32),
        .MAX  ('1),
        .WRAP (1'b1)
    ) u_stat_core_stall (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (core_stall),
        .cnt (stat_core_stall)
    );
`endif

    a_stall_is_host: assert property (@(posedge clk) disable iff (!rst)
        core_stall |-> (gnt_dbg == GNT_HOST));
    a_starve_bound: assert property (@(posedge clk) disable iff (!rst)
        starve_cnt <= LIM);

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int LIM = 4;

    logic        clk;
    logic        rst;
    logic        core_req, core_we;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        core_stall;
    logic        host_req, host_we;
    logic [31:0] host_addr, host_wdata;
    logic        host_ack;
    logic [31:0] host_rdata;
    logic        host_rvalid;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_host_gnt, stat_core_stall;
`endif

    int checks = 0;
    int passes = 0;

    dmem_arbiter #(.AW(32), .DW(32), .STARVE_LIM(LIM)) dut (
        .clk         (clk),
        .rst         (rst),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_rdata  (core_rdata),
        .core_stall  (core_stall),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_ack    (host_ack),
        .host_rdata  (host_rdata),
        .host_rvalid (host_rvalid),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_host_gnt   (stat_host_gnt),
        .stat_core_stall (stat_core_stall)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // data_mem stand-in: combinational read, write on rising edge
    logic [31:0] dmem [256];
    assign mem_rdata = dmem[mem_addr[9:2]];
    always @(posedge clk) if (mem_we) dmem[mem_addr[9:2]] <= mem_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] ref_mem [256];
    int          losses;          // consecutive cycles the pending host request lost
    logic        m_rvalid;
    logic [31:0] m_rdata;
    int unsigned m_hg, m_cs;

    always @(negedge clk) begin
        logic        host_wins, core_wins, we;
        logic [31:0] addr, wd;
        if (!rst) begin
            losses   = 0;
            m_rvalid = 1'b0;
            m_rdata  = '0;
            m_hg     = 0;
            m_cs     = 0;
            chk("m_rst_mem_we", {31'b0, mem_we}, 32'd0);
            chk("m_rst_rvalid", {31'b0, host_rvalid}, 32'd0);
        end else begin
            host_wins = host_req && (!core_req || losses >= LIM);
            core_wins = core_req && !host_wins;
            addr = host_wins ? host_addr  : core_addr;
            wd   = host_wins ? host_wdata : core_wdata;
            we   = host_wins ? host_we : (core_wins && core_we);
            chk("m_host_ack",   {31'b0, host_ack},   {31'b0, host_wins});
            chk("m_core_stall", {31'b0, core_stall}, {31'b0, host_wins && core_req});
            chk("m_mem_we",     {31'b0, mem_we},     {31'b0, we});
            chk("m_mem_addr",   mem_addr,  addr);
            chk("m_mem_wdata",  mem_wdata, wd);
            chk("m_core_rdata", core_rdata, ref_mem[addr[9:2]]);
            chk("m_host_rvalid", {31'b0, host_rvalid}, {31'b0, m_rvalid});
            chk("m_host_rdata", host_rdata, m_rdata);
`ifdef DMEM_ARB_STATS_EN
            chk("m_stat_host_gnt",   stat_host_gnt,   m_hg);
            chk("m_stat_core_stall", stat_core_stall, m_cs);
            if (host_wins) m_hg++;
            if (host_wins && core_req) m_cs++;
`endif
            // state as it will be after the coming rising edge
            m_rvalid = host_wins && !host_we;
            if (m_rvalid) m_rdata = ref_mem[host_addr[9:2]];
            if (we) ref_mem[addr[9:2]] = wd;
            if (host_wins || !host_req) losses = 0;
            else if (losses < LIM) losses++;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic core_drv(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        core_req = r; core_we = w; core_addr = a; core_wdata = d;
    endtask

    task automatic host_drv(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        host_req = r; host_we = w; host_addr = a; host_wdata = d;
    endtask

    task automatic idle();
        core_drv(0, 0, 32'h0, 32'h0);
        host_drv(0, 0, 32'h0, 32'h0);
    endtask

    // Core read traffic with a host read pending from cycle 0: the host must
    // win exactly in cycle LIM, then a fresh host request in the next cycle
    // must lose again (counter restarted).
    task automatic run_starve();
        core_drv(1, 0, 32'h40, 32'h0);
        host_drv(1, 0, 32'h44, 32'h0);
        for (int c = 0; c <= LIM; c++) begin
            #1;
            chk($sformatf("starve_ack_c%0d", c),   {31'b0, host_ack},   {31'b0, c == LIM});
            chk($sformatf("starve_stall_c%0d", c), {31'b0, core_stall}, {31'b0, c == LIM});
            step();
        end
        #1;
        chk("starve_restart_ack", {31'b0, host_ack}, 32'd0);
        step();
        idle();
        step();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            dmem[i]    = '0;
            ref_mem[i] = '0;
        end
        rst = 1'b0;
        idle();
        repeat (3) step();
        chk("rst_rvalid", {31'b0, host_rvalid}, 32'd0);
        chk("rst_rdata",  host_rdata, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        rst = 1'b1;
        step();

        // host write with core idle, then host read back
        host_drv(1, 1, 32'h10, 32'hDEADBEEF);
        #1;
        chk("hw_ack",    {31'b0, host_ack}, 32'd1);
        chk("hw_mem_we", {31'b0, mem_we},   32'd1);
        step();
        host_drv(1, 0, 32'h10, 32'h0);
        #1;
        chk("hr_ack", {31'b0, host_ack}, 32'd1);
        step();
        idle();
        #1;
        chk("hr_rvalid", {31'b0, host_rvalid}, 32'd1);
        chk("hr_rdata",  host_rdata, 32'hDEADBEEF);
        step();
        #1;
        chk("hr_rvalid_drop", {31'b0, host_rvalid}, 32'd0);
        chk("hr_rdata_hold",  host_rdata, 32'hDEADBEEF);

        // core-only read
        core_drv(1, 0, 32'h10, 32'h0);
        #1;
        chk("cr_rdata", core_rdata, 32'hDEADBEEF);
        chk("cr_stall", {31'b0, core_stall}, 32'd0);
        chk("cr_ack",   {31'b0, host_ack},   32'd0);
        step();
        idle();
        step();

        run_starve();

        // same-address collision under starvation
        core_drv(1, 1, 32'h20, 32'h1);
        host_drv(1, 1, 32'h20, 32'h2);
        repeat (LIM) step();
        #1;
        chk("col_host_ack",   {31'b0, host_ack}, 32'd1);
        chk("col_host_wdata", mem_wdata, 32'h2);
        step();
        host_drv(0, 0, 32'h0, 32'h0);
        #1;
        chk("col_core_we",    {31'b0, mem_we}, 32'd1);
        chk("col_core_wdata", mem_wdata, 32'h1);
        step();
        core_drv(1, 0, 32'h20, 32'h0);
        #1;
        chk("col_readback", core_rdata, 32'h1);
        step();
        idle();
        step();

        // reset mid host read grant
        host_drv(1, 0, 32'h10, 32'h0);
        #1;
        chk("rr_ack", {31'b0, host_ack}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("rr_mem_we", {31'b0, mem_we}, 32'd0);
        step();
        chk("rr_no_rvalid", {31'b0, host_rvalid}, 32'd0);
        idle();
        rst = 1'b1;
        step();
        chk("rr_no_rvalid2", {31'b0, host_rvalid}, 32'd0);

        // host write presented while in reset: no write strobe
        host_drv(1, 1, 32'h30, 32'h55);
        rst = 1'b0;
        #1;
        chk("rw_ack",    {31'b0, host_ack}, 32'd1);
        chk("rw_mem_we", {31'b0, mem_we},   32'd0);
        step();
        idle();
        rst = 1'b1;
        step();
        host_drv(1, 0, 32'h30, 32'h0);
        step();
        idle();
        #1;
        chk("rw_not_written", host_rdata, 32'h0);
        step();

        // two losses, then reset: count restarts from zero after release
        core_drv(1, 0, 32'h40, 32'h0);
        host_drv(1, 0, 32'h44, 32'h0);
        step();
        step();
        #2;
        rst = 1'b0;
        step();
        idle();
        rst = 1'b1;
        step();
        run_starve();

`ifdef DMEM_ARB_STATS_EN
        rst = 1'b0;
        step();
        chk("stat_rst_hg", stat_host_gnt, 32'd0);
        chk("stat_rst_cs", stat_core_stall, 32'd0);
        rst = 1'b1;
        step();
        repeat (3) run_starve();
        chk("stat_host_gnt",   stat_host_gnt,   32'd3);
        chk("stat_core_stall", stat_core_stall, 32'd3);
`endif

        repeat (2) step();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the MIPS core's load/store path and a host/DMA port (debug loader, test bench, future DMA engine).
- Sits between the core datapath (alu_result as address, wd as write data, rd_data as read data, memwrite as write enable) and data_mem.
- Core has fixed priority. A starvation counter guarantees host progress. The arbiter stalls the core whenever the host owns the memory.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- STARVE_LIM, 4: consecutive cycles a pending host request can lose to the core before it is forced through. Legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- core_req  in  1  core load/store this cycle (memwrite | memread).
- core_we  in  1  core write enable.
- core_addr  in  AW  core byte address.
- core_wdata  in  DW  core store data.
- core_rdata  out  DW  load data to core.
- core_stall  out  1  core must hold PC and suppress register write this cycle.
- host_req  in  1  host request; held until host_ack.
- host_we  in  1  host write enable.
- host_addr  in  AW  host address.
- host_wdata  in  DW  host write data.
- host_ack  out  1  one-cycle pulse in the cycle the host access is performed.
- host_rdata  out  DW  registered host read data.
- host_rvalid  out  1  one-cycle pulse, the cycle after a host read ack.
- mem_we  out  1  to data_mem write enable.
- mem_addr  out  AW  to data_mem address.
- mem_wdata  out  DW  to data_mem write data.
- mem_rdata  in  DW  from data_mem; combinational read.

Behaviour:
- Grant decision is combinational each cycle from the requests and the registered starve_cnt (4 bits):
  - gnt_host = host_req & (~core_req | starve_cnt == STARVE_LIM).
  - gnt_core = core_req & ~gnt_host.
- Memory mux:
  - gnt_host: mem_addr=host_addr, mem_wdata=host_wdata, mem_we=host_we.
  - gnt_core: core fields.
  - No grant: mem_addr=core_addr, mem_wdata=core_wdata, mem_we=0.
  - mem_we is forced 0 while rst is low.
- core_rdata = mem_rdata at all times (zero latency, as single-cycle core requires).
- core_stall = core_req & gnt_host. On a stall cycle the core re-presents the same request next cycle.
- host_ack = gnt_host (combinational, single cycle). The host may change fields or drop host_req the cycle after ack.
- On the edge ending a host read grant: host_rdata <= mem_rdata; host_rvalid <= 1 for exactly one cycle. host_rdata holds its value until the next host read.
- starve_cnt:
  - Increments when host_req & gnt_core.
  - Clears to 0 when gnt_host or ~host_req.
  - Saturates at STARVE_LIM.
  - Consequence: a pending host request waits at most STARVE_LIM cycles under continuous core traffic.
- Simultaneous core write and host write to the same address: only the granted side writes. The loser is retried next cycle, so last writer = later grant.
- Reset (async, rst=0):
  - starve_cnt=0, host_rdata=0, host_rvalid=0.
  - host_ack and core_stall may follow inputs combinationally, but mem_we=0.
- Reset asserted mid-host-read: host_rvalid is not produced. The host must reissue after reset.
- Write latency: data visible to a read on the cycle after the write edge, for either port.

Optional Feature:
- DMEM_ARB_STATS_EN defined:
  - Adds outputs stat_host_gnt (32) and stat_core_stall (32).
  - stat_host_gnt increments on every gnt_host.
  - stat_core_stall increments on every core_stall.
  - Both wrap at 2^32 and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package dmem_arb_pkg: AW/DW defaults, STARVE_W=4, and a grant encoding enum {GNT_NONE, GNT_CORE, GNT_HOST} used for debug and assertions.
- One sub-module, arb_sat_ctr: parameterised saturating/clearing counter, used for starve_cnt. The stats counters use wrap mode, selected by parameter.

Test Plan:
- Host write, core idle: host_req=1, host_we=1, addr=0x10, wdata=0xDEADBEEF -> host_ack same cycle, mem_we=1. A host read of 0x10 next gives host_rvalid one cycle later with host_rdata=0xDEADBEEF.
- Core only: core_req=1, core_we=0, addr=0x10 -> core_rdata=0xDEADBEEF same cycle, core_stall=0, host_ack=0.
- Starvation, STARVE_LIM=4: core_req held high, host_req high from cycle 0 -> host_ack in cycle 4, core_stall=1 only in cycle 4, starve_cnt back to 0 in cycle 5.
- Same-address collision: core writes 0x1, host writes 0x2 to 0x20 with starve forced -> host wins first, core write lands next cycle. Readback of 0x20 = 0x1.
- Async reset during host read grant: rst low mid-cycle -> mem_we=0 immediately, host_rvalid stays 0, starve_cnt=0 after release.
- DMEM_ARB_STATS_EN: run the starvation scenario 3 times -> stat_host_gnt=3, stat_core_stall=3.
